// File: rtl/inc_pulse_pkg.sv
// Shared types and constants for the increment pulse generator.
package inc_pulse_pkg;

  // FSM states: idle, one-cycle pulse, inter-pulse gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } ips_state_t;

  // Width of the gap timer; GAP must fit in 0..15.
  localparam int GAP_W = 4;

  // Default parameter values.
  localparam int WIDTH_DEF  = 8;
  localparam int GAP_DEF    = 2;
  localparam int PEND_W_DEF = 4;

endpackage

// File: rtl/sat_event_counter.sv
// Pending-event counter: counts accepted events up, issued pulses down,
// and withholds ready at full scale so the count never wraps.
module sat_event_counter #(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              up_req,
  input  logic              dn,
  output logic [PEND_W-1:0] count,
  output logic              ready
);

  localparam logic [PEND_W-1:0] FULL = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);

  logic [PEND_W-1:0] count_q;
  logic [PEND_W-1:0] count_d;
  logic              up_s;

  // Ready depends on the registered count only; a clear discards a same-edge accept.
  always_comb begin
    ready = (count_q != FULL);
    up_s  = up_req && ready && !clr;
  end

  // Next count: clear wins, otherwise net of accept and issue.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (up_s && !dn) begin
      count_d = count_q + ONE;
    end else if (!up_s && dn) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/inc_pulse_gen.sv
// Rate-limited increment pulse generator with clear and a shadow issue count.
module inc_pulse_gen
  import inc_pulse_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int GAP    = GAP_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic              clr_req,
  output logic              inc,
  output logic              clr,
  output logic [PEND_W-1:0] pending,
  output logic [WIDTH-1:0]  issued,
  output logic              busy
);

  localparam bit              GAP_ZERO   = (GAP == 0);
  localparam logic [GAP_W-1:0] GAP_RELOAD = (GAP > 0) ? GAP_W'(GAP - 1) : {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic [WIDTH-1:0] ISS_ONE    = WIDTH'(1);

  ips_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             inc_q, inc_d;
  logic             clr_q, clr_d;
  logic [WIDTH-1:0] issued_q, issued_d;
  logic             issue_s;
  logic             pend_nz_s;

  sat_event_counter #(
    .PEND_W (PEND_W)
  ) u_pend (
    .clk    (aclk),
    .srst   (srst),
    .clr    (clr_req),
    .up_req (evt_valid),
    .dn     (issue_s),
    .count  (pending),
    .ready  (evt_ready)
  );

  assign pend_nz_s = (pending != {PEND_W{1'b0}});

  // Next-state logic: pulse scheduling, gap timing, clear abort and issue counting.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_nz_s) begin
          state_d = PULSE;
          issue_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (GAP_ZERO) begin
          if (pend_nz_s) begin
            state_d = PULSE;
            issue_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d   = GAP_RELOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (gap_q == {GAP_W{1'b0}}) begin
          if (pend_nz_s) begin
            state_d = PULSE;
            issue_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = {GAP_W{1'b0}};
      end
    endcase

    // A clear aborts any pulse that would have been issued at this edge.
    if (clr_req) begin
      state_d = IDLE;
      gap_d   = {GAP_W{1'b0}};
      issue_s = 1'b0;
    end else begin
      issue_s = issue_s;
    end

    inc_d = issue_s;
    clr_d = clr_req;

    if (clr_req) begin
      issued_d = {WIDTH{1'b0}};
    end else if (issue_s) begin
      issued_d = issued_q + ISS_ONE;
    end else begin
      issued_d = issued_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q  <= IDLE;
      gap_q    <= {GAP_W{1'b0}};
      inc_q    <= 1'b0;
      clr_q    <= 1'b0;
      issued_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      issued_q <= issued_d;
    end
  end

  assign inc    = inc_q;
  assign clr    = clr_q;
  assign issued = issued_q;
  assign busy   = (state_q != IDLE) || pend_nz_s;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Self-checking bench: three generators (GAP=2, GAP=0, GAP=1) share stimulus
// and are compared each cycle against a pulse-budget reference model.
module tb_inc_pulse_gen;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       srst, evt_valid, clr_req;
  logic       rdy [3];
  logic       inc [3];
  logic       clr [3];
  logic       busy[3];
  logic [3:0] pend[3];
  logic [7:0] iss [3];

  inc_pulse_gen #(.WIDTH(8), .GAP(2), .PEND_W(4)) dut_g2 (
    .aclk(aclk), .srst(srst), .evt_valid(evt_valid), .evt_ready(rdy[0]), .clr_req(clr_req),
    .inc(inc[0]), .clr(clr[0]), .pending(pend[0]), .issued(iss[0]), .busy(busy[0]));
  inc_pulse_gen #(.WIDTH(8), .GAP(0), .PEND_W(4)) dut_g0 (
    .aclk(aclk), .srst(srst), .evt_valid(evt_valid), .evt_ready(rdy[1]), .clr_req(clr_req),
    .inc(inc[1]), .clr(clr[1]), .pending(pend[1]), .issued(iss[1]), .busy(busy[1]));
  inc_pulse_gen #(.WIDTH(8), .GAP(1), .PEND_W(4)) dut_g1 (
    .aclk(aclk), .srst(srst), .evt_valid(evt_valid), .evt_ready(rdy[2]), .clr_req(clr_req),
    .inc(inc[2]), .clr(clr[2]), .pending(pend[2]), .issued(iss[2]), .busy(busy[2]));

  // Downstream counter fed by the GAP=1 generator.
  logic [7:0] ds_cnt;
  always @(posedge aclk) begin
    if (srst) ds_cnt <= 8'd0;
    else if (clr[2]) ds_cnt <= 8'd0;
    else if (inc[2]) ds_cnt <= ds_cnt + 8'd1;
  end

  // Reference model: events queue up; a pulse may fire when something is
  // pending and the previous pulse's GAP idle cycles have elapsed.
  int gap_of[3] = '{2, 0, 1};
  int m_pend[3], m_gap_left[3], m_in_gap[3], m_inc[3], m_clr[3], m_issued[3], m_acc[3];
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (srst) begin
        m_pend[d] = 0; m_gap_left[d] = 0; m_in_gap[d] = 0;
        m_inc[d] = 0; m_clr[d] = 0; m_issued[d] = 0;
      end else if (clr_req) begin
        m_pend[d] = 0; m_gap_left[d] = 0; m_in_gap[d] = 0;
        m_inc[d] = 0; m_clr[d] = 1; m_issued[d] = 0;
      end else begin
        int fire, acc;
        fire = (m_pend[d] > 0 && m_gap_left[d] == 0) ? 1 : 0;
        acc  = (evt_valid && m_pend[d] != 15) ? 1 : 0;
        m_acc[d] += acc;
        m_pend[d] = m_pend[d] + acc - fire;
        m_inc[d]  = fire;
        m_clr[d]  = 0;
        if (fire != 0) begin
          m_issued[d] = (m_issued[d] + 1) % 256;
          m_gap_left[d] = gap_of[d];
          m_in_gap[d] = 0;
        end else if (m_gap_left[d] > 0) begin
          m_gap_left[d]--;
          m_in_gap[d] = 1;
        end else begin
          m_in_gap[d] = 0;
        end
      end
    end
  endtask

  function automatic logic [15:0] obs_vec(int d);
    return {inc[d], clr[d], pend[d], iss[d], rdy[d], busy[d]};
  endfunction

  function automatic logic [15:0] exp_vec(int d);
    logic [3:0] p;
    logic [7:0] i;
    p = 4'(m_pend[d]);
    i = 8'(m_issued[d]);
    return {m_inc[d] != 0, m_clr[d] != 0, p, i, m_pend[d] != 15,
            (m_pend[d] != 0) || (m_inc[d] != 0) || (m_in_gap[d] != 0)};
  endfunction

  function automatic bit all_idle();
    return (m_pend[0] == 0 && m_pend[1] == 0 && m_pend[2] == 0 &&
            m_inc[0] == 0 && m_inc[1] == 0 && m_inc[2] == 0 &&
            m_in_gap[0] == 0 && m_in_gap[1] == 0 && m_in_gap[2] == 0);
  endfunction

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; evt_valid = 1'b1; clr_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== 16'b0_0_0000_00000000_1_0) begin
          n_err++;
          $display("FAIL reset dut%0d got %h expected %h", d, obs_vec(d), 16'b0_0_0000_00000000_1_0);
        end
      end
    end
    srst = 1'b0; evt_valid = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_single();
    evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    n_cmp++;
    if (inc[0] !== 1'b0 || pend[0] !== 4'd1) begin
      n_err++;
      $display("FAIL single_accept got inc=%b pend=%0d expected inc=0 pend=1", inc[0], pend[0]);
    end
    tick();
    n_cmp++;
    if (inc[0] !== 1'b1 || iss[0] !== 8'd1 || pend[0] !== 4'd0) begin
      n_err++;
      $display("FAIL single_pulse got inc=%b iss=%0d pend=%0d expected 1/1/0", inc[0], iss[0], pend[0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL single dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (busy[0] !== 1'b0 || inc[0] !== 1'b0) begin
          n_err++;
          $display("FAIL single_busy got busy=%b inc=%b expected 0/0", busy[0], inc[0]);
        end
      end
    end
  endtask

  task automatic test_burst();
    int acc0[3], pulses[3], last_pulse, cyc, not_ready, bad_space;
    for (int d = 0; d < 3; d++) begin acc0[d] = m_acc[d]; pulses[d] = 0; end
    last_pulse = -1; cyc = 0; not_ready = 0; bad_space = 0;
    evt_valid = 1'b1;
    for (int c = 0; c < 150; c++) begin
      if (c == 30) evt_valid = 1'b0;
      if (c > 30 && all_idle()) break;
      tick();
      cyc++;
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL burst dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
        if (inc[d] === 1'b1) pulses[d]++;
      end
      if (rdy[0] === 1'b0) not_ready++;
      if (inc[0] === 1'b1) begin
        if (last_pulse >= 0 && cyc - last_pulse != 3) bad_space++;
        last_pulse = cyc;
      end
    end
    n_cmp++;
    if (!all_idle()) begin
      n_err++;
      $display("FAIL burst_timeout got busy expected idle within budget");
    end
    n_cmp++;
    if (not_ready == 0) begin
      n_err++;
      $display("FAIL burst_backpressure got 0 not-ready cycles expected >0");
    end
    n_cmp++;
    if (bad_space != 0) begin
      n_err++;
      $display("FAIL burst_spacing got %0d bad gaps expected 0", bad_space);
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (pulses[d] != m_acc[d] - acc0[d]) begin
        n_err++;
        $display("FAIL burst_count dut%0d got %0d pulses expected %0d", d, pulses[d], m_acc[d] - acc0[d]);
      end
    end
  endtask

  task automatic test_gap0_burst();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    evt_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) evt_valid = 1'b0;
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL gap0 dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
      if (inc[1] === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    n_cmp++;
    if (cnt != 4 || last - first != 3 || first != 1 || iss[1] !== 8'd4) begin
      n_err++;
      $display("FAIL gap0_run got cnt=%0d first=%0d last=%0d iss=%0d expected 4/1/4/4", cnt, first, last, iss[1]);
    end
  endtask

  task automatic test_clear();
    bit reached;
    reached = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    evt_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL clear_fill dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
      if (m_pend[0] == 5 && m_in_gap[0] != 0) begin reached = 1'b1; break; end
    end
    n_cmp++;
    if (!reached) begin
      n_err++;
      $display("FAIL clear_setup_timeout got no pend=5 in gap expected it within 40 cycles");
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0; evt_valid = 1'b0;
    n_cmp++;
    if (clr[0] !== 1'b1 || pend[0] !== 4'd0 || iss[0] !== 8'd0 || inc[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_edge got clr=%b pend=%0d iss=%0d inc=%b expected 1/0/0/0", clr[0], pend[0], iss[0], inc[0]);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d) || inc[d] !== 1'b0 || clr[d] !== 1'b0) begin
          n_err++;
          $display("FAIL clear_after dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      evt_valid = 1'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 39) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
    end
    clr_req = 1'b0; evt_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int acc0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    acc0 = m_acc[2];
    evt_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (m_acc[2] - acc0 >= 260) evt_valid = 1'b0;
      if (evt_valid == 1'b0 && all_idle()) break;
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++;
          $display("FAIL wrap dut%0d cyc%0d got %h expected %h", d, c, obs_vec(d), exp_vec(d));
        end
      end
    end
    evt_valid = 1'b0;
    tick();
    n_cmp++;
    if (m_acc[2] - acc0 != 260 || iss[2] !== 8'd4 || ds_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL wrap_count got acc=%0d iss=%0d ds=%0d expected 260/4/4", m_acc[2] - acc0, iss[2], ds_cnt);
    end
    evt_valid = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0; evt_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs_vec(d) !== 16'b0_0_0000_00000000_1_0) begin
        n_err++;
        $display("FAIL wrap_srst dut%0d got %h expected %h", d, obs_vec(d), 16'b0_0_0000_00000000_1_0);
      end
    end
    tick();
    n_cmp++;
    if (ds_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_ds_reset got %0d expected 0", ds_cnt);
    end
  endtask

  initial begin
    srst = 1'b1; evt_valid = 1'b0; clr_req = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = 0; m_gap_left[d] = 0; m_in_gap[d] = 0;
      m_inc[d] = 0; m_clr[d] = 0; m_issued[d] = 0; m_acc[d] = 0;
    end
    test_reset();
    test_single();
    test_burst();
    test_gap0_burst();
    test_clear();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
